// File: rtl/datamem_pkg.sv
// Shared definitions for the data memory responder: FSM encoding, counter width
// and the word-index width helper.
package datamem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/acknowledge bus between the core datapath (master) and the data memory (slave).
// DataMem_Err exists only when DATAMEM_CHECK_EN is defined.
interface data_mem_responder_if;
  logic        DataMem_Req;
  logic        DataMem_WE;
  logic [31:0] DataMem_Addr;
  logic [31:0] DataMem_WD;
  logic [31:0] DataMem_RD;
  logic        DataMem_Ack;
  logic        DataMem_Busy;
`ifdef DATAMEM_CHECK_EN
  logic        DataMem_Err;

  modport master (
    output DataMem_Req, DataMem_WE, DataMem_Addr, DataMem_WD,
    input  DataMem_RD, DataMem_Ack, DataMem_Busy, DataMem_Err
  );
  modport slave (
    input  DataMem_Req, DataMem_WE, DataMem_Addr, DataMem_WD,
    output DataMem_RD, DataMem_Ack, DataMem_Busy, DataMem_Err
  );
`else
  modport master (
    output DataMem_Req, DataMem_WE, DataMem_Addr, DataMem_WD,
    input  DataMem_RD, DataMem_Ack, DataMem_Busy
  );
  modport slave (
    input  DataMem_Req, DataMem_WE, DataMem_Addr, DataMem_WD,
    output DataMem_RD, DataMem_Ack, DataMem_Busy
  );
`endif
endinterface

// File: rtl/data_mem_array.sv
// DEPTH x 32 storage: synchronous write, asynchronous read, asynchronous clear.
module data_mem_array
  import datamem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic             DataMem_CLK,
  input  logic             DataMem_RST,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wd,
  output logic [31:0]      o_rd
);
  logic [31:0] r_mem [DEPTH];

  // NOTE: the array is cleared by reset because loads after reset must return 0;
  // a plain RAM would leave this out and could map to a memory macro.
  always_ff @(posedge DataMem_CLK or posedge DataMem_RST) begin
    if (DataMem_RST) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      r_mem[i_idx] <= i_wd;
    end
  end

  assign o_rd = r_mem[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Request/acknowledge data memory for the MIPS core with WAIT_STATES response latency.
// Define DATAMEM_CHECK_EN to add alignment/range checking and the DataMem_Err output.
module data_mem_responder
  import datamem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input logic                 DataMem_CLK,
  input logic                 DataMem_RST,
  data_mem_responder_if.slave bus
);
  localparam int IDX_W = idx_width(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;
  logic             r_we;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wd, r_rd;
  logic             w_accept, w_commit, w_we, w_bad;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_wd, w_rdata;

`ifdef DATAMEM_CHECK_EN
  logic r_bad, r_err, w_req_bad;
  assign w_req_bad = (bus.DataMem_Addr[1:0] != 2'b00) || (bus.DataMem_Addr[31:IDX_W+2] != '0);
  assign w_bad     = (r_state == IDLE) ? w_req_bad : r_bad;
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{bus.DataMem_Addr[31:IDX_W+2], bus.DataMem_Addr[1:0]};
  assign w_bad         = 1'b0;
`endif

  // With zero wait states the access commits straight from IDLE, so the request
  // fields are used directly instead of their latched copies.
  assign w_accept = (r_state == IDLE) && bus.DataMem_Req;
  assign w_commit = (w_next_state == RESP) && (r_state != RESP);
  assign w_we     = (r_state == IDLE) ? bus.DataMem_WE : r_we;
  assign w_idx    = (r_state == IDLE) ? bus.DataMem_Addr[IDX_W+1:2] : r_idx;
  assign w_wd     = (r_state == IDLE) ? bus.DataMem_WD : r_wd;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge DataMem_CLK or posedge DataMem_RST) begin
    if (DataMem_RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // NOTE: defaults first, so no path through the case leaves a signal unassigned
  // and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (bus.DataMem_Req) begin
          w_next_cnt   = WAIT_INIT;
          w_next_state = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt != '0) w_next_cnt = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) w_next_state = RESP;
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge DataMem_CLK or posedge DataMem_RST) begin
    if (DataMem_RST) begin
      r_we  <= 1'b0;
      r_idx <= '0;
      r_wd  <= '0;
      r_rd  <= '0;
`ifdef DATAMEM_CHECK_EN
      r_bad <= 1'b0;
      r_err <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_we  <= bus.DataMem_WE;
        r_idx <= bus.DataMem_Addr[IDX_W+1:2];
        r_wd  <= bus.DataMem_WD;
`ifdef DATAMEM_CHECK_EN
        r_bad <= w_req_bad;
`endif
      end
      if (w_commit && !w_we) r_rd <= w_bad ? '0 : w_rdata;
`ifdef DATAMEM_CHECK_EN
      r_err <= w_commit && w_bad;
`endif
    end
  end

  data_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .DataMem_CLK (DataMem_CLK),
    .DataMem_RST (DataMem_RST),
    .i_we        (w_commit && w_we && !w_bad),
    .i_idx       (w_idx),
    .i_wd        (w_wd),
    .o_rd        (w_rdata)
  );

  assign bus.DataMem_RD   = r_rd;
  assign bus.DataMem_Ack  = (r_state == RESP);
  assign bus.DataMem_Busy = (r_state != IDLE);
`ifdef DATAMEM_CHECK_EN
  assign bus.DataMem_Err  = r_err;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance,
// with a queue of expected load data checked at each Ack.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [31:0] sb_q[$];

  data_mem_responder_if b2 ();
  data_mem_responder_if b0 ();

  data_mem_responder #(.DEPTH(64), .WAIT_STATES(2)) dut2 (
    .DataMem_CLK (clk),
    .DataMem_RST (rst),
    .bus         (b2)
  );

  data_mem_responder #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
    .DataMem_CLK (clk),
    .DataMem_RST (rst),
    .bus         (b0)
  );

  always #5 clk = ~clk;

  function automatic logic err2();
`ifdef DATAMEM_CHECK_EN
    return b2.DataMem_Err;
`else
    return 1'b0;
`endif
  endfunction

  // One access on the 2-wait-state instance; starts just after a rising edge with
  // the FSM idle and returns just after the edge that leaves RESP.
  task automatic acc2(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int lat,
                      output int busy_cnt, output logic busy0);
    b2.DataMem_Req  = 1'b1;
    b2.DataMem_WE   = we;
    b2.DataMem_Addr = addr;
    b2.DataMem_WD   = wd;
    rd = 'x; err = 1'bx; lat = -1; busy_cnt = 0;
    @(negedge clk);
    busy0 = b2.DataMem_Busy;
    @(posedge clk);
    #1 b2.DataMem_Req = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (b2.DataMem_Busy) busy_cnt++;
      if (b2.DataMem_Ack) begin
        lat = k;
        rd  = b2.DataMem_RD;
        err = err2();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if (b2.DataMem_RD !== 32'h0) begin n_fail++; $display("FAIL reset_rd2 got=%h exp=0", b2.DataMem_RD); end
    n_chk++; if (b2.DataMem_Ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack2 got=%b exp=0", b2.DataMem_Ack); end
    n_chk++; if (b2.DataMem_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy2 got=%b exp=0", b2.DataMem_Busy); end
    n_chk++; if (b0.DataMem_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy0 got=%b exp=0", b0.DataMem_Busy); end
`ifdef DATAMEM_CHECK_EN
    n_chk++; if (b2.DataMem_Err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", b2.DataMem_Err); end
`endif
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_timing();
    logic [31:0] rd; logic err, b0s; int lat, bc;
    acc2(1'b1, 32'h10, 32'hDEADBEEF, rd, err, lat, bc, b0s);
    n_chk++; if (b0s !== 1'b0) begin n_fail++; $display("FAIL st_busy_cycle0 got=%b exp=0", b0s); end
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL st_ack_cycle got=%0d exp=3", lat); end
    n_chk++; if (bc !== 3) begin n_fail++; $display("FAIL st_busy_cycles got=%0d exp=3", bc); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL st_err got=%b exp=0", err); end
    n_chk++; if (b2.DataMem_Busy !== 1'b0 || b2.DataMem_Ack !== 1'b0) begin
      n_fail++; $display("FAIL st_after_ack busy=%b ack=%b exp=0/0", b2.DataMem_Busy, b2.DataMem_Ack);
    end
  endtask

  task automatic test_load();
    logic [31:0] rd, exp; logic err, b0s; int lat, bc;
    sb_q.push_back(32'hDEADBEEF);
    acc2(1'b0, 32'h10, 32'h0, rd, err, lat, bc, b0s);
    exp = sb_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL ld_0x10 got=%h exp=%h", rd, exp); end
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL ld_ack_cycle got=%0d exp=3", lat); end
    sb_q.push_back(32'h0);
    acc2(1'b0, 32'h14, 32'h0, rd, err, lat, bc, b0s);
    exp = sb_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL ld_0x14 got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_patterns();
    logic [31:0] addrs[4];
    logic [31:0] data[4];
    logic [31:0] rd, exp; logic err, b0s; int lat, bc;
    addrs = '{32'h0, 32'h4, 32'hFC, 32'h80};
    foreach (data[i]) data[i] = $urandom();
    foreach (addrs[i]) acc2(1'b1, addrs[i], data[i], rd, err, lat, bc, b0s);
    foreach (addrs[i]) begin
      sb_q.push_back(data[i]);
      acc2(1'b0, addrs[i], 32'h0, rd, err, lat, bc, b0s);
      exp = sb_q.pop_front();
      n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL pat_ld[%0d] addr=%h got=%h exp=%h", i, addrs[i], rd, exp); end
    end
    // a store must leave RD holding the last load result
    acc2(1'b1, 32'h44, 32'h5A5A5A5A, rd, err, lat, bc, b0s);
    n_chk++; if (rd !== data[3]) begin n_fail++; $display("FAIL st_rd_hold got=%h exp=%h", rd, data[3]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp; logic exp_ack;
    b0.DataMem_Req = 1'b1; b0.DataMem_WE = 1'b1; b0.DataMem_Addr = 32'h8; b0.DataMem_WD = 32'h12345678;
    @(posedge clk);
    #1 b0.DataMem_Req = 1'b0;
    @(negedge clk);
    n_chk++; if (b0.DataMem_Ack !== 1'b1 || b0.DataMem_Busy !== 1'b1) begin
      n_fail++; $display("FAIL w0_store_ack ack=%b busy=%b exp=1/1", b0.DataMem_Ack, b0.DataMem_Busy);
    end
    @(posedge clk);
    #1;
    repeat (3) sb_q.push_back(32'h12345678);
    b0.DataMem_Req = 1'b1; b0.DataMem_WE = 1'b0;
    for (int c = 0; c < 6; c++) begin
      exp_ack = (c == 1 || c == 3 || c == 5);
      @(negedge clk);
      n_chk++; if (b0.DataMem_Ack !== exp_ack || b0.DataMem_Busy !== exp_ack) begin
        n_fail++; $display("FAIL b2b_cycle%0d ack=%b busy=%b exp=%b/%b", c, b0.DataMem_Ack, b0.DataMem_Busy, exp_ack, exp_ack);
      end
      if (b0.DataMem_Ack === 1'b1 && sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        n_chk++; if (b0.DataMem_RD !== exp) begin n_fail++; $display("FAIL b2b_rd%0d got=%h exp=%h", c, b0.DataMem_RD, exp); end
      end
      @(posedge clk);
      #1;
    end
    b0.DataMem_Req = 1'b0;
    n_chk++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing_acks left=%0d exp=0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_req_during_busy();
    logic [31:0] rd, exp; logic err, b0s; int lat, bc, acks, ack_c;
    acks = 0; ack_c = -1;
    b2.DataMem_Req = 1'b1; b2.DataMem_WE = 1'b1; b2.DataMem_Addr = 32'h30; b2.DataMem_WD = 32'hAAAA0001;
    @(posedge clk);
    #1 b2.DataMem_WD = 32'hBBBB0002;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (b2.DataMem_Ack === 1'b1) begin acks++; ack_c = c; end
      @(posedge clk);
      #1;
      if (c == 2) b2.DataMem_Req = 1'b0;
    end
    n_chk++; if (acks !== 1) begin n_fail++; $display("FAIL busy_req_acks got=%0d exp=1", acks); end
    n_chk++; if (ack_c !== 3) begin n_fail++; $display("FAIL busy_req_ack_cycle got=%0d exp=3", ack_c); end
    sb_q.push_back(32'hAAAA0001);
    acc2(1'b0, 32'h30, 32'h0, rd, err, lat, bc, b0s);
    exp = sb_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL busy_req_data got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, exp; logic err, b0s; int lat, bc, acks;
    acks = 0;
    b2.DataMem_Req = 1'b1; b2.DataMem_WE = 1'b1; b2.DataMem_Addr = 32'h20; b2.DataMem_WD = 32'hCAFEF00D;
    @(posedge clk);
    #1 b2.DataMem_Req = 1'b0;
    @(negedge clk);
    n_chk++; if (b2.DataMem_Busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got=%b exp=1", b2.DataMem_Busy); end
    rst = 1'b1;
    #1;
    n_chk++; if (b2.DataMem_RD !== 32'h0 || b2.DataMem_Busy !== 1'b0 || b2.DataMem_Ack !== 1'b0) begin
      n_fail++; $display("FAIL rmid_outputs rd=%h busy=%b ack=%b exp=0/0/0", b2.DataMem_RD, b2.DataMem_Busy, b2.DataMem_Ack);
    end
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (b2.DataMem_Ack === 1'b1) acks++;
    end
    n_chk++; if (acks !== 0) begin n_fail++; $display("FAIL rmid_stray_ack got=%0d exp=0", acks); end
    @(posedge clk);
    #1;
    sb_q.push_back(32'h0);
    acc2(1'b0, 32'h20, 32'h0, rd, err, lat, bc, b0s);
    exp = sb_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL rmid_ld_0x20 got=%h exp=%h", rd, exp); end
    sb_q.push_back(32'h0);
    acc2(1'b0, 32'h10, 32'h0, rd, err, lat, bc, b0s);
    exp = sb_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL rmid_ld_0x10_cleared got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_addr_check();
    logic [31:0] rd, exp; logic err, b0s; int lat, bc;
    acc2(1'b1, 32'h0, 32'h11112222, rd, err, lat, bc, b0s);
`ifdef DATAMEM_CHECK_EN
    acc2(1'b1, 32'h102, 32'h33334444, rd, err, lat, bc, b0s);
    n_chk++; if (err !== 1'b1 || lat !== 3) begin n_fail++; $display("FAIL chk_st_0x102 err=%b lat=%0d exp=1/3", err, lat); end
    n_chk++; if (b2.DataMem_Err !== 1'b0) begin n_fail++; $display("FAIL chk_err_after_ack got=%b exp=0", b2.DataMem_Err); end
    sb_q.push_back(32'h11112222);
    acc2(1'b0, 32'h0, 32'h0, rd, err, lat, bc, b0s);
    exp = sb_q.pop_front();
    n_chk++; if (rd !== exp || err !== 1'b0) begin n_fail++; $display("FAIL chk_mem_unchanged rd=%h err=%b exp=%h/0", rd, err, exp); end
    sb_q.push_back(32'h0);
    acc2(1'b0, 32'h100, 32'h0, rd, err, lat, bc, b0s);
    exp = sb_q.pop_front();
    n_chk++; if (rd !== exp || err !== 1'b1) begin n_fail++; $display("FAIL chk_ld_0x100 rd=%h err=%b exp=%h/1", rd, err, exp); end
    acc2(1'b0, 32'hFC, 32'h0, rd, err, lat, bc, b0s);
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL chk_ld_0xFC_err got=%b exp=0", err); end
`else
    acc2(1'b1, 32'h100, 32'h33334444, rd, err, lat, bc, b0s);
    sb_q.push_back(32'h33334444);
    acc2(1'b0, 32'h0, 32'h0, rd, err, lat, bc, b0s);
    exp = sb_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL wrap_0x100 got=%h exp=%h", rd, exp); end
    acc2(1'b1, 32'h6, 32'h55556666, rd, err, lat, bc, b0s);
    sb_q.push_back(32'h55556666);
    acc2(1'b0, 32'h4, 32'h0, rd, err, lat, bc, b0s);
    exp = sb_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL wrap_misaligned got=%h exp=%h", rd, exp); end
`endif
  endtask

  initial begin
    b2.DataMem_Req = 1'b0; b2.DataMem_WE = 1'b0; b2.DataMem_Addr = '0; b2.DataMem_WD = '0;
    b0.DataMem_Req = 1'b0; b0.DataMem_WE = 1'b0; b0.DataMem_Addr = '0; b0.DataMem_WD = '0;
    test_reset();
    test_store_timing();
    test_load();
    test_patterns();
    test_back_to_back();
    test_req_during_busy();
    test_reset_mid();
    test_addr_check();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder-side data memory for the 32-bit MIPS core: accepts load/store requests issued by the datapath (address from the ALU result, store data from register-file port 2) and returns read data after a configurable number of wait states. It sits between the datapath/control unit and the storage array. It gives the core a req/ack handshake, so a multi-cycle or stall-capable core can model a slow data memory.

## Interface
Parameters:
- DEPTH, 64, number of 32-bit words; power of two, minimum 4.
- WAIT_STATES, 2, extra cycles between request acceptance and response; 0–15.

Ports:
- DataMem_CLK  in  1  single clock, rising edge.
- DataMem_RST  in  1  reset, asynchronous, active-high.
- DataMem_Req  in  1  request strobe, sampled only in IDLE.
- DataMem_WE  in  1  1 = store, 0 = load; sampled with Req.
- DataMem_Addr  in  32  byte address, sampled with Req.
- DataMem_WD  in  32  store data, sampled with Req.
- DataMem_RD  out  32  load data; valid while Ack is high, held until the next load response.
- DataMem_Ack  out  1  one-cycle response pulse.
- DataMem_Busy  out  1  high from the cycle after acceptance through the Ack cycle.
- DataMem_Err  out  1  access-error flag, qualified by Ack. Present only with the checking macro.

## Operation
- Three-state FSM.
  - IDLE: if Req is high, latch WE/Addr/WD. Load the wait counter with WAIT_STATES. Go to WAIT, or go directly to RESP when WAIT_STATES = 0.
  - WAIT: decrement the counter. When the counter is 1, or the state was entered with a count of 0, go to RESP. Total time in WAIT is exactly WAIT_STATES cycles.
  - RESP: Ack = 1 for one cycle, then IDLE unconditionally.
- Word index = Addr[log2(DEPTH)+1:2].
  - Without checking, the upper address bits and Addr[1:0] are ignored, so addresses wrap modulo DEPTH*4.
- Store: array word written at the clock edge that enters RESP. RD unchanged.
- Load: RD loaded at the clock edge that enters RESP with the array word.
  - A load from a word stored earlier returns the stored value.
- Req while Busy is ignored; no queueing.
  - Req held high continuously is re-accepted in the IDLE cycle after Ack.
  - Maximum throughput: one access per WAIT_STATES+2 cycles.
- Reset, asynchronous:
  - FSM returns to IDLE; counter 0.
  - All array words cleared to 0.
  - RD = 0, Ack = 0, Busy = 0, Err = 0.
  - Reset mid-access aborts it: no write, no Ack.

## Timing
- Req accepted in cycle n (IDLE) → Busy high in cycles n+1 … n+1+WAIT_STATES → Ack high in cycle n+1+WAIT_STATES only.
- Earliest next acceptance: cycle n+2+WAIT_STATES.
- All outputs are registered or decoded from state only; no combinational path from the request inputs to any output.

## Configuration
- DATAMEM_CHECK_EN defined:
  - Err is present.
  - In RESP, Err = 1 if the latched Addr[1:0] ≠ 0 or Addr ≥ DEPTH*4.
  - On error, the store is suppressed and load RD = 0.
  - Err is 0 outside the Ack cycle.
- DATAMEM_CHECK_EN undefined:
  - No Err port and no checking logic.
  - Misaligned or out-of-range addresses wrap silently as described above.

## Structure
- Shared package datamem_pkg:
  - State encoding constants IDLE/WAIT/RESP.
  - Wait-counter width (4 bits).
  - Word-index width as a function of DEPTH.
- One sub-module, data_mem_array: DEPTH×32 storage with a synchronous write port, a read port used by the response register, and asynchronous clear on DataMem_RST.
- The FSM, counter and address/error decode stay in data_mem_responder.

## Test plan
- Reset, then store 0xDEADBEEF at 0x10 with WAIT_STATES = 2 (Req in cycle 0) → Busy in cycles 1–3, Ack only in cycle 3, no Err.
- Load 0x10 → RD = 0xDEADBEEF in the Ack cycle. Load 0x14 → RD = 0x00000000.
- WAIT_STATES = 0, Req held high for 6 cycles with loads → Ack in cycles 1, 3, 5; Busy equals Ack.
- Req pulsed again during Busy → ignored; exactly one Ack; stored data is that of the first request.
- Assert reset in the middle of a store to 0x20 → outputs 0 immediately; a later load of 0x20 returns 0.
- DATAMEM_CHECK_EN defined, DEPTH = 64:
  - Store to 0x102 → Err = 1 with Ack, memory unchanged.
  - Load from 0x100 → Err = 1, RD = 0.
  - Without the macro, a store to 0x100 overwrites word 0.
